// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for a 5-stage pipeline.
// Shadows rd/control of in-flight instructions and drives EX operand mux selects.
module fwd_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel,
    output logic             stall,
    output logic             ex_bubble
);

    localparam logic [SEL_W-1:0] SEL_RF    = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_EXMEM = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_MEMWB = SEL_W'(2);
    localparam logic [REG_W-1:0] REG_ZERO  = '0;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } idex_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } exmem_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
    } memwb_t;

    idex_t  idex_d,  idex_q;
    exmem_t exmem_d, exmem_q;
    memwb_t memwb_d, memwb_q;

    logic exmem_can_fwd;
    logic memwb_can_fwd;
    logic load_use;

    // A producer in EX/MEM is usable only if it is not a load; its data is not ready yet.
    always_comb begin
        exmem_can_fwd = exmem_q.valid && exmem_q.regwrite && !exmem_q.memread
                        && (exmem_q.rd != REG_ZERO);
        memwb_can_fwd = memwb_q.valid && memwb_q.regwrite && (memwb_q.rd != REG_ZERO);
    end

    function automatic logic [SEL_W-1:0] pick_sel(input logic [REG_W-1:0] rs);
        logic [SEL_W-1:0] sel;
        sel = SEL_RF;
        if (exmem_can_fwd && (exmem_q.rd == rs)) begin
            sel = SEL_EXMEM;
        end else if (memwb_can_fwd && (memwb_q.rd == rs)) begin
            sel = SEL_MEMWB;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a_sel = SEL_RF;
        fwd_b_sel = SEL_RF;
        if (idex_q.valid) begin
            fwd_a_sel = pick_sel(idex_q.rs1);
            fwd_b_sel = pick_sel(idex_q.rs2);
        end
    end

    // A load in EX whose rd feeds the ID instruction holds ID for one cycle.
    always_comb begin
        load_use = id_valid && idex_q.valid && idex_q.memread
                   && (idex_q.rd != REG_ZERO)
                   && ((idex_q.rd == id_rs1) || (idex_q.rd == id_rs2));
        stall     = load_use && !flush;
        ex_bubble = stall || flush;
    end

    always_comb begin
        idex_d = '0;
        if (!ex_bubble) begin
            idex_d.valid    = id_valid;
            idex_d.rs1      = id_rs1;
            idex_d.rs2      = id_rs2;
            idex_d.rd       = id_rd;
            idex_d.regwrite = id_regwrite;
            idex_d.memread  = id_memread;
        end

        exmem_d          = '0;
        exmem_d.valid    = idex_q.valid;
        exmem_d.rd       = idex_q.rd;
        exmem_d.regwrite = idex_q.regwrite;
        exmem_d.memread  = idex_q.memread;

        memwb_d          = '0;
        memwb_d.valid    = exmem_q.valid;
        memwb_d.rd       = exmem_q.rd;
        memwb_d.regwrite = exmem_q.regwrite;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: inputs change on the falling edge,
// outputs are checked 1ns later, well before the next rising edge.
module tb_fwd_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int SEL_W = 2;

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic [REG_W-1:0] id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             flush;
    logic [SEL_W-1:0] fwd_a_sel;
    logic [SEL_W-1:0] fwd_b_sel;
    logic             stall;
    logic             ex_bubble;

    int checks = 0;
    int errors = 0;

    fwd_hazard_ctrl #(.REG_W(REG_W), .SEL_W(SEL_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rd      (id_rd),
        .id_regwrite(id_regwrite),
        .id_memread (id_memread),
        .flush      (flush),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel),
        .stall      (stall),
        .ex_bubble  (ex_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] a, input logic [1:0] b,
                           input logic st, input logic bub);
        chk({tag, ".fwd_a_sel"}, 8'(fwd_a_sel), 8'(a));
        chk({tag, ".fwd_b_sel"}, 8'(fwd_b_sel), 8'(b));
        chk({tag, ".stall"},     8'(stall),     8'(st));
        chk({tag, ".ex_bubble"}, 8'(ex_bubble), 8'(bub));
    endtask

    // ALU op: writes rd, not a load.
    task automatic alu(input int rs1, input int rs2, input int rd);
        id_valid    = 1'b1;
        id_rs1      = REG_W'(rs1);
        id_rs2      = REG_W'(rs2);
        id_rd       = REG_W'(rd);
        id_regwrite = 1'b1;
        id_memread  = 1'b0;
    endtask

    task automatic load(input int rs1, input int rd);
        alu(rs1, 0, rd);
        id_memread = 1'b1;
    endtask

    // Invalid ID slot; fields hold junk that must be ignored.
    task automatic nop();
        id_valid    = 1'b0;
        id_rs1      = 5'd5;
        id_rs2      = 5'd3;
        id_rd       = 5'd9;
        id_regwrite = 1'b1;
        id_memread  = 1'b1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        flush = 1'b0;
        repeat (4) next_cycle();
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        load(1, 5);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_out("reset_exit", 2'b00, 2'b00, 1'b0, 1'b0);
        alu(5, 5, 6);
        #1;
        chk_out("reset_dep_id", 2'b00, 2'b00, 1'b0, 1'b0);
        drain();

        // add x5 ; sub x6,x5,x7
        alu(1, 2, 5);
        #1;
        chk_out("alu_c0", 2'b00, 2'b00, 1'b0, 1'b0);
        next_cycle();
        alu(5, 7, 6);
        #1;
        chk_out("alu_c1", 2'b00, 2'b00, 1'b0, 1'b0);
        next_cycle();
        nop();
        #1;
        chk_out("alu_sub_ex", 2'b01, 2'b00, 1'b0, 1'b0);
        drain();

        // lw x5 ; add x6,x5,x5
        load(1, 5);
        #1;
        chk_out("ld_c0", 2'b00, 2'b00, 1'b0, 1'b0);
        next_cycle();
        alu(5, 5, 6);
        #1;
        chk_out("ld_stall", 2'b00, 2'b00, 1'b1, 1'b1);
        next_cycle();
        #1;
        chk_out("ld_after_stall", 2'b00, 2'b00, 1'b0, 1'b0);
        next_cycle();
        nop();
        #1;
        chk_out("ld_add_ex", 2'b10, 2'b10, 1'b0, 1'b0);
        drain();

        // addi x0,x0,1 ; add x1,x0,x0
        alu(0, 0, 0);
        next_cycle();
        alu(0, 0, 1);
        #1;
        chk_out("x0_c1", 2'b00, 2'b00, 1'b0, 1'b0);
        next_cycle();
        nop();
        #1;
        chk_out("x0_ex", 2'b00, 2'b00, 1'b0, 1'b0);
        drain();

        // lw x0 ; add x1,x0,x0 must not stall
        load(2, 0);
        next_cycle();
        alu(0, 0, 1);
        #1;
        chk_out("ldx0_use", 2'b00, 2'b00, 1'b0, 1'b0);
        drain();

        // add x3 ; add x3 ; add x4,x3,x3 -> younger producer wins
        alu(1, 2, 3);
        next_cycle();
        alu(1, 2, 3);
        next_cycle();
        alu(3, 3, 4);
        next_cycle();
        nop();
        #1;
        chk_out("younger_wins", 2'b01, 2'b01, 1'b0, 1'b0);
        drain();

        // distance 2: add x7 ; nop ; add x8,x7,x0
        alu(1, 2, 7);
        next_cycle();
        nop();
        next_cycle();
        alu(7, 0, 8);
        next_cycle();
        nop();
        #1;
        chk_out("dist2", 2'b10, 2'b00, 1'b0, 1'b0);
        drain();

        // distance 3: add x9 ; nop ; nop ; add x10,x9,x9
        alu(1, 2, 9);
        next_cycle();
        nop();
        next_cycle();
        next_cycle();
        alu(9, 9, 10);
        next_cycle();
        nop();
        #1;
        chk_out("dist3", 2'b00, 2'b00, 1'b0, 1'b0);
        drain();

        // load-use pair with flush in the stall cycle
        load(1, 5);
        next_cycle();
        alu(5, 5, 6);
        flush = 1'b1;
        #1;
        chk_out("flush_stall", 2'b00, 2'b00, 1'b0, 1'b1);
        next_cycle();
        flush = 1'b0;
        nop();
        #1;
        chk_out("flush_next", 2'b00, 2'b00, 1'b0, 1'b0);
        next_cycle();
        #1;
        chk_out("flush_next2", 2'b00, 2'b00, 1'b0, 1'b0);
        drain();

        // plain flush kills the ID producer: add x11 (flushed) ; add x12,x11,x11
        alu(1, 2, 11);
        flush = 1'b1;
        #1;
        chk_out("flush_alu", 2'b00, 2'b00, 1'b0, 1'b1);
        next_cycle();
        flush = 1'b0;
        alu(11, 11, 12);
        next_cycle();
        nop();
        #1;
        chk_out("flush_killed", 2'b00, 2'b00, 1'b0, 1'b0);
        drain();

        // reset during a load-use stall discards the load
        load(1, 5);
        next_cycle();
        alu(5, 5, 6);
        #1;
        chk_out("rst_stall_pre", 2'b00, 2'b00, 1'b1, 1'b1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        chk_out("rst_stall_post", 2'b00, 2'b00, 1'b0, 1'b0);
        next_cycle();
        nop();
        #1;
        chk_out("rst_stall_ex", 2'b00, 2'b00, 1'b0, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and hazard controller for the 5-stage pipeline. It drives the select inputs of the two EX-stage operand 3:1 muxes, which choose between the register file, the EX/MEM result and the MEM/WB result. It tracks the destination register of every in-flight instruction in its own ID/EX, EX/MEM and MEM/WB shadow registers. It raises a load-use stall and inserts a bubble into EX.

## Interface
Parameters:
- REG_W, 5, register-index width
- SEL_W, 2, forwarding-select width; fixed at 2

Ports:
- clk  in  1  pipeline clock; everything updates on the rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  instruction present in ID
- id_rs1  in  REG_W  ID source register 1
- id_rs2  in  REG_W  ID source register 2
- id_rd  in  REG_W  ID destination register
- id_regwrite  in  1  ID instruction writes rd
- id_memread  in  1  ID instruction is a load
- flush  in  1  branch/jump taken in EX; kills the ID instruction
- fwd_a_sel  out  SEL_W  select for the EX operand-A mux
- fwd_b_sel  out  SEL_W  select for the EX operand-B mux
- stall  out  1  hold PC and IF/ID; the ID instruction is not accepted this cycle
- ex_bubble  out  1  a bubble enters ID/EX this edge; either stall or flush is true

## Operation
- Shadow stages:
  - ID/EX holds {valid, rs1, rs2, rd, regwrite, memread}.
  - EX/MEM holds {valid, rd, regwrite, memread}.
  - MEM/WB holds {valid, rd, regwrite}.
- Advance every cycle. EX/MEM takes ID/EX, and MEM/WB takes EX/MEM, unconditionally.
- ID/EX load:
  - If flush or stall: load a bubble. Valid, regwrite and memread are 0; the index fields are 0.
  - Otherwise: load the ID fields, with valid = id_valid.
- Select encoding: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result. 11 is never driven.
- fwd_a_sel for the ID/EX rs1:
  - 01 if EX/MEM is valid, regwrite, not memread, rd != 0 and rd == rs1.
  - Else 10 if MEM/WB is valid, regwrite, rd != 0 and rd == rs1.
  - Else 00.
- fwd_b_sel: same rule applied to rs2.
- EX/MEM has priority over MEM/WB because it holds the younger producer.
- x0 is never forwarded.
- fwd selects are 00 whenever ID/EX is not valid.
- stall = id_valid & ID/EX valid & ID/EX memread & ID/EX rd != 0 & (ID/EX rd == id_rs1 | ID/EX rd == id_rs2).
- stall is forced to 0 when flush is 1.
- Loads resolve through exactly one bubble. The EX/MEM forwarding path therefore never selects a load, since EX/MEM memread blocks selection.
- The register file is write-before-read. No ID-stage bypass is generated here.

## Timing
- Reset:
  - All shadow stages clear on the first rising edge with rst = 1.
  - Outputs after that edge: fwd_a_sel = 00, fwd_b_sel = 00, stall = 0, ex_bubble = 0.
  - rst overrides flush and stall.
- fwd_a_sel and fwd_b_sel are combinational from registered state only, so they are stable for the whole cycle.
- stall and ex_bubble are combinational from the ID inputs and ID/EX state, in the same cycle.
- Load-use:
  - Load L is in EX in cycle n and dependent D is in ID: stall = 1 in cycle n.
  - D enters EX in cycle n+2 with sel = 10.
- Back-to-back ALU ops with a dependency: sel = 01 in the consumer's EX cycle, with no stall.
- Distance-2 dependency: sel = 10.
- Distance-3 and beyond: sel = 00, served by the write-before-read register file.
- Simultaneous flush and stall: one bubble. stall reads 0, ex_bubble reads 1, and the ID instruction is discarded.
- Reset mid-stall: all in-flight state is discarded. The next cycle shows stall = 0.

## Test plan
- Reset with rst = 1 for 2 cycles, then deassert -> every output is 0; sel is 00 for any ID input until an instruction reaches EX.
- Sequence add x5 then sub x6,x5,x7 -> in sub's EX cycle, fwd_a_sel = 01 and fwd_b_sel = 00; stall is never 1.
- Sequence lw x5, then add x6,x5,x5 -> stall = 1 for exactly one cycle; in add's EX cycle, fwd_a_sel = fwd_b_sel = 10.
- Sequence addi x0,x0,1 then add x1,x0,x0 -> sel stays 00 and stall stays 0.
- Sequence add x3 (writes x3), then add x3 again, then add x4,x3,x3 -> sel = 01 for both operands, since the younger producer wins.
- Load-use pair with flush = 1 in the stall cycle -> stall = 0, ex_bubble = 1; next cycle ID/EX is not valid and sel = 00.
